// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32I datapath (lw, sw, R-type, beq).
// Memory handshake on req/ready with a timeout watchdog that halts on a stall.
module multicycle_control #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_read,
   output logic       mem_write,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] result_src,
   output logic       retire,
   output logic       illegal_instr,
   output logic       bus_error,
   output logic [3:0] state_dbg
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      ALUWB    = 4'd7,
      BEQ      = 4'd8,
      HALT     = 4'd9
   } state_t;

   localparam logic [6:0] OP_LW = 7'b0000011;
   localparam logic [6:0] OP_SW = 7'b0100011;
   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_BR = 7'b1100011;
   localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

   state_t     state;
   state_t     next;
   logic [7:0] cnt;
   logic       waiting;
   logic       timeout;

   assign waiting = (state == FETCH || state == MEMREAD ||
                     state == MEMWRITE) && !mem_ready;
   assign timeout = waiting && (MEM_TIMEOUT != 0) && (cnt == LIMIT);

   always_comb begin
      next = state;
      case (state)
         FETCH:    if (mem_ready) next = DECODE;
         DECODE: begin
            if (opcode == OP_LW || opcode == OP_SW) next = MEMADR;
            else if (opcode == OP_R) next = EXECR;
            else if (opcode == OP_BR) next = BEQ;
            else next = HALT;
         end
         MEMADR:   next = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
         MEMREAD:  if (mem_ready) next = MEMWB;
         MEMWRITE: if (mem_ready) next = FETCH;
         MEMWB:    next = FETCH;
         EXECR:    next = ALUWB;
         ALUWB:    next = FETCH;
         BEQ:      next = FETCH;
         HALT:     next = HALT;
         default:  next = HALT;
      endcase
      if (timeout) next = HALT;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= FETCH;
         cnt           <= 8'd0;
         illegal_instr <= 1'b0;
         bus_error     <= 1'b0;
      end else begin
         state <= next;
         if (timeout) bus_error <= 1'b1;
         if (state == DECODE && next == HALT) illegal_instr <= 1'b1;
         // on timeout the counter is left saturated at the limit
         if (timeout) cnt <= cnt;
         else if (next != state) cnt <= 8'd0;
         else if (waiting && cnt != 8'hff) cnt <= cnt + 8'd1;
      end
   end

   logic mr, mw, ir, pw, rw, rt;

   always_comb begin
      mr         = 1'b0;
      mw         = 1'b0;
      ir         = 1'b0;
      pw         = 1'b0;
      rw         = 1'b0;
      rt         = 1'b0;
      adr_src    = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      result_src = 2'b00;
      case (state)
         FETCH: begin
            mr         = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir         = mem_ready;
            pw         = mem_ready;
         end
         DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
         end
         MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
         end
         MEMREAD: begin
            mr      = 1'b1;
            adr_src = 1'b1;
         end
         MEMWB: begin
            rw         = 1'b1;
            result_src = 2'b01;
            rt         = 1'b1;
         end
         MEMWRITE: begin
            mw      = 1'b1;
            adr_src = 1'b1;
            rt      = mem_ready;
         end
         EXECR: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
         end
         ALUWB: begin
            rw = 1'b1;
            rt = 1'b1;
         end
         BEQ: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b01;
            pw        = zero;
            rt        = 1'b1;
         end
         default: ;
      endcase
   end

   // reset lands in FETCH, so strobes must be masked while rst is held
   assign mem_read  = mr & ~rst;
   assign mem_write = mw & ~rst;
   assign ir_write  = ir & ~rst;
   assign pc_write  = pw & ~rst;
   assign reg_write = rw & ~rst;
   assign retire    = rt & ~rst;
   assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed vector table, corner sequences,
// and random stimulus against a route-based reference model.
module tb_multicycle_control;

   localparam logic [6:0] LW = 7'b0000011;
   localparam logic [6:0] SW = 7'b0100011;
   localparam logic [6:0] RT = 7'b0110011;
   localparam logic [6:0] BQ = 7'b1100011;
   localparam logic [6:0] IL = 7'b0010011;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] opcode = LW;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;

   logic       mem_read[2], mem_write[2], adr_src[2], ir_write[2];
   logic       pc_write[2], reg_write[2], retire[2];
   logic       illegal_instr[2], bus_error[2];
   logic [1:0] alu_src_a[2], alu_src_b[2], alu_op[2], result_src[2];
   logic [3:0] state_dbg[2];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   multicycle_control dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .mem_read(mem_read[0]),
      .mem_write(mem_write[0]), .adr_src(adr_src[0]),
      .ir_write(ir_write[0]), .pc_write(pc_write[0]),
      .reg_write(reg_write[0]), .alu_src_a(alu_src_a[0]),
      .alu_src_b(alu_src_b[0]), .alu_op(alu_op[0]),
      .result_src(result_src[0]), .retire(retire[0]),
      .illegal_instr(illegal_instr[0]), .bus_error(bus_error[0]),
      .state_dbg(state_dbg[0])
   );

   multicycle_control #(.MEM_TIMEOUT(4)) dut4 (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .mem_read(mem_read[1]),
      .mem_write(mem_write[1]), .adr_src(adr_src[1]),
      .ir_write(ir_write[1]), .pc_write(pc_write[1]),
      .reg_write(reg_write[1]), .alu_src_a(alu_src_a[1]),
      .alu_src_b(alu_src_b[1]), .alu_op(alu_op[1]),
      .result_src(result_src[1]), .retire(retire[1]),
      .illegal_instr(illegal_instr[1]), .bus_error(bus_error[1]),
      .state_dbg(state_dbg[1])
   );

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   function automatic logic [5:0] strobes(int i);
      return {mem_read[i], mem_write[i], ir_write[i],
              pc_write[i], reg_write[i], retire[i]};
   endfunction

   function automatic logic [14:0] ovec(int i);
      return {mem_read[i], mem_write[i], adr_src[i], ir_write[i],
              pc_write[i], reg_write[i], alu_src_a[i], alu_src_b[i],
              alu_op[i], result_src[i], retire[i]};
   endfunction

   // expected full output bundle for a state code, from the output table
   function automatic logic [14:0] exp_vec(int c, bit rdy, bit z);
      logic mr, mw, as, ir, pw, rw, rt;
      logic [1:0] sa, sb, op, rs;
      {mr, mw, as, ir, pw, rw, rt} = '0;
      {sa, sb, op, rs} = '0;
      case (c)
         0: begin mr = 1; sb = 2; rs = 2; ir = rdy; pw = rdy; end
         1: begin sa = 1; sb = 1; end
         2: begin sa = 2; sb = 1; end
         3: begin mr = 1; as = 1; end
         4: begin rw = 1; rs = 1; rt = 1; end
         5: begin mw = 1; as = 1; rt = rdy; end
         6: begin sa = 2; op = 2; end
         7: begin rw = 1; rt = 1; end
         8: begin sa = 2; op = 1; pw = z; rt = 1; end
         default: ;
      endcase
      return {mr, mw, as, ir, pw, rw, sa, sb, op, rs, rt};
   endfunction

   // model: each instruction kind follows a fixed route of state codes
   typedef struct {
      int kind;
      int pos;
      int wcnt;
      bit halt;
      bit ill;
      bit berr;
   } mdl_t;

   int route[4][5] = '{'{0, 1, 2, 3, 4}, '{0, 1, 2, 5, 0},
                       '{0, 1, 6, 7, 0}, '{0, 1, 8, 0, 0}};
   int rlen[4] = '{5, 4, 4, 3};

   function automatic mdl_t m_init();
      mdl_t m;
      m.kind = 0; m.pos = 0; m.wcnt = 0;
      m.halt = 0; m.ill = 0; m.berr = 0;
      return m;
   endfunction

   function automatic int m_code(mdl_t m);
      if (m.halt) return 9;
      if (m.pos < 2) return m.pos;
      return route[m.kind][m.pos];
   endfunction

   function automatic mdl_t m_step(mdl_t m, int t, logic [6:0] op,
                                   bit rdy);
      int c;
      c = m_code(m);
      if (m.halt) return m;
      if ((c == 0 || c == 3 || c == 5) && !rdy) begin
         if (t != 0 && m.wcnt == t - 1) begin
            m.halt = 1; m.berr = 1;
         end else if (m.wcnt < 255) m.wcnt++;
         return m;
      end
      m.wcnt = 0;
      if (m.pos == 1) begin
         case (op)
            LW: m.kind = 0;
            SW: m.kind = 1;
            RT: m.kind = 2;
            BQ: m.kind = 3;
            default: begin m.halt = 1; m.ill = 1; end
         endcase
         m.pos = 2;
      end else if (c == 2) begin
         m.kind = (op == LW) ? 0 : 1;
         m.pos++;
      end else if (m.pos == rlen[m.kind] - 1) m.pos = 0;
      else m.pos++;
      return m;
   endfunction

   typedef struct {
      logic [6:0] op;
      bit         z;
      bit         rdy;
      int         st;
      logic [5:0] sb;
      logic [1:0] aop;
   } vec_t;

   vec_t tbl[$];

   task automatic add(logic [6:0] op, bit z, bit rdy, int st,
                      logic [5:0] sb, logic [1:0] aop);
      vec_t v;
      v.op = op; v.z = z; v.rdy = rdy; v.st = st; v.sb = sb; v.aop = aop;
      tbl.push_back(v);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("rst_state", 32'(state_dbg[i]), 0);
         chk("rst_strobes", 32'(strobes(i)), 0);
         chk("rst_flags", 32'({illegal_instr[i], bus_error[i]}), 0);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   mdl_t m[2];
   int   tl[2] = '{16, 4};
   logic [6:0] ops[4] = '{LW, SW, RT, BQ};

   initial begin
      add(LW, 0, 1, 0, 6'b101100, 2'b00);
      add(LW, 0, 1, 1, 6'b000000, 2'b00);
      add(LW, 0, 1, 2, 6'b000000, 2'b00);
      add(LW, 0, 1, 3, 6'b100000, 2'b00);
      add(LW, 0, 1, 4, 6'b000011, 2'b00);
      add(RT, 0, 1, 0, 6'b101100, 2'b00);
      add(RT, 0, 1, 1, 6'b000000, 2'b00);
      add(RT, 0, 1, 6, 6'b000000, 2'b10);
      add(RT, 0, 1, 7, 6'b000011, 2'b00);
      add(BQ, 1, 1, 0, 6'b101100, 2'b00);
      add(BQ, 1, 1, 1, 6'b000000, 2'b00);
      add(BQ, 1, 1, 8, 6'b000101, 2'b01);
      add(BQ, 0, 1, 0, 6'b101100, 2'b00);
      add(BQ, 0, 1, 1, 6'b000000, 2'b00);
      add(BQ, 0, 1, 8, 6'b000001, 2'b01);
      add(SW, 0, 1, 0, 6'b101100, 2'b00);
      add(SW, 0, 1, 1, 6'b000000, 2'b00);
      add(SW, 0, 1, 2, 6'b000000, 2'b00);
      add(SW, 0, 0, 5, 6'b010000, 2'b00);
      add(SW, 0, 0, 5, 6'b010000, 2'b00);
      add(SW, 0, 0, 5, 6'b010000, 2'b00);
      add(SW, 0, 1, 5, 6'b010001, 2'b00);
      add(IL, 0, 0, 0, 6'b100000, 2'b00);
      add(IL, 0, 1, 0, 6'b101100, 2'b00);
      add(IL, 0, 1, 1, 6'b000000, 2'b00);
      add(IL, 0, 1, 9, 6'b000000, 2'b00);
      add(IL, 0, 1, 9, 6'b000000, 2'b00);

      @(negedge clk);
      do_reset();

      // directed table; the 4-cycle instance sees ready exactly at its limit
      foreach (tbl[k]) begin
         opcode = tbl[k].op; zero = tbl[k].z; mem_ready = tbl[k].rdy;
         #1;
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("tbl%0d_state_u%0d", k, i),
                32'(state_dbg[i]), 32'(tbl[k].st));
            chk($sformatf("tbl%0d_strobes_u%0d", k, i),
                32'(strobes(i)), 32'(tbl[k].sb));
            chk($sformatf("tbl%0d_aluop_u%0d", k, i),
                32'(alu_op[i]), 32'(tbl[k].aop));
         end
         @(negedge clk);
      end
      for (int i = 0; i < 2; i++) begin
         chk("illegal_sticky", 32'(illegal_instr[i]), 1);
         chk("no_bus_error", 32'(bus_error[i]), 0);
      end

      // asynchronous reset while stalled in MEMREAD
      do_reset();
      opcode = LW; mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      mem_ready = 1'b0;
      @(negedge clk);
      #1;
      chk("memread_state", 32'(state_dbg[0]), 3);
      chk("memread_req", 32'(mem_read[0]), 1);
      #1 rst = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("async_rst_state", 32'(state_dbg[i]), 0);
         chk("async_rst_strobes", 32'(strobes(i)), 0);
      end
      @(posedge clk);
      #1;
      chk("rst_held_strobes", 32'(strobes(0)), 0);
      chk("rst_held_state", 32'(state_dbg[0]), 0);
      @(negedge clk);
      rst = 1'b0;

      // watchdog: ready stuck low in FETCH
      @(negedge clk);
      do_reset();
      mem_ready = 1'b0;
      for (int c = 0; c < 20; c++) begin
         #1;
         chk($sformatf("wd16_state_c%0d", c), 32'(state_dbg[0]),
             (c < 16) ? 0 : 9);
         chk($sformatf("wd4_state_c%0d", c), 32'(state_dbg[1]),
             (c < 4) ? 0 : 9);
         if (c >= 4) chk("wd4_strobes", 32'(strobes(1)), 0);
         @(negedge clk);
      end
      chk("wd16_berr", 32'(bus_error[0]), 1);
      chk("wd4_berr", 32'(bus_error[1]), 1);
      mem_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("halt_sticks", 32'(state_dbg[1]), 9);
      chk("halt_strobes", 32'(strobes(1)), 0);
      @(negedge clk);

      // random stimulus against the model
      do_reset();
      m[0] = m_init();
      m[1] = m_init();
      for (int n = 0; n < 3000; n++) begin
         if ((m[0].halt && m[1].halt && $urandom_range(0, 3) == 0) ||
             $urandom_range(0, 299) == 0) begin
            rst = 1'b1;
            #1;
            for (int i = 0; i < 2; i++) begin
               chk("rnd_rst_state", 32'(state_dbg[i]), 0);
               chk("rnd_rst_strobes", 32'(strobes(i)), 0);
               m[i] = m_init();
            end
            @(negedge clk);
            rst = 1'b0;
            continue;
         end
         begin
            int r;
            r = $urandom_range(0, 15);
            opcode = (r == 0) ? IL : ops[r % 4];
         end
         zero = 1'($urandom_range(0, 1));
         mem_ready = ($urandom_range(0, 9) < 7);
         #1;
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("rnd_state_u%0d", i), 32'(state_dbg[i]),
                32'(m_code(m[i])));
            chk($sformatf("rnd_outs_u%0d", i), 32'(ovec(i)),
                32'(exp_vec(m_code(m[i]), mem_ready, zero)));
            chk($sformatf("rnd_ill_u%0d", i), 32'(illegal_instr[i]),
                32'(m[i].ill));
            chk($sformatf("rnd_berr_u%0d", i), 32'(bus_error[i]),
                32'(m[i].berr));
         end
         @(posedge clk);
         for (int i = 0; i < 2; i++)
            m[i] = m_step(m[i], tl[i], opcode, mem_ready);
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle RV32I datapath. Sequences fetch, decode, address, memory, execute and writeback for lw, sw, R-type and beq.
- Produces the 2-bit ALUop consumed by the ALU-control decoder (00 add, 01 sub/branch, 10 R-type funct decode), plus all datapath mux selects and write strobes.
- Talks to a unified instruction/data memory over a req/ready handshake, with a timeout watchdog.

Parameters:
- MEM_TIMEOUT, default 16: maximum cycles a memory state may wait for mem_ready before bus error. 0 disables the watchdog. Legal range 0..255.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  7  instruction[6:0] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_read  out  1  read request
- mem_write  out  1  write request
- adr_src  out  1  memory address select: 0 PC, 1 ALUOut
- ir_write  out  1  load IR and oldPC
- pc_write  out  1  load PC
- reg_write  out  1  register file write
- alu_src_a  out  2  00 PC, 01 oldPC, 10 rs1 register
- alu_src_b  out  2  00 rs2 register, 01 immediate, 10 constant 4
- alu_op  out  2  to ALU control
- result_src  out  2  00 ALUOut, 01 memory data, 10 ALU result
- retire  out  1  one-cycle pulse when an instruction completes
- illegal_instr  out  1  sticky: unsupported opcode seen
- bus_error  out  1  sticky: memory timeout
- state_dbg  out  4  current state encoding

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, BEQ=8, HALT=9. Unused encodings go to HALT.
- Reset (async assert, sync release):
  - state=FETCH, wait counter=0, illegal_instr=0, bus_error=0.
  - While rst=1, all strobes (mem_read, mem_write, ir_write, pc_write, reg_write, retire) are forced to 0.
- Moore outputs per state; unlisted outputs are 0.
  - FETCH: mem_read=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10; ir_write=pc_write=mem_ready.
  - DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALUOut).
  - MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00.
  - MEMREAD: mem_read=1, adr_src=1.
  - MEMWB: reg_write=1, result_src=01, retire=1.
  - MEMWRITE: mem_write=1, adr_src=1, retire=mem_ready.
  - EXECR: alu_src_a=10, alu_src_b=00, alu_op=10.
  - ALUWB: reg_write=1, result_src=00, retire=1.
  - BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero, retire=1.
  - HALT: all strobes 0.
- Transitions:
  - FETCH→DECODE when mem_ready, else stay.
  - DECODE: opcode 0000011 or 0100011 → MEMADR; 0110011 → EXECR; 1100011 → BEQ; any other → HALT and set illegal_instr.
  - MEMADR: to MEMREAD if opcode=0000011, else MEMWRITE.
  - MEMREAD→MEMWB on mem_ready, else stay.
  - MEMWRITE→FETCH on mem_ready, else stay.
  - MEMWB, ALUWB, BEQ→FETCH.
  - EXECR→ALUWB.
  - HALT stays until reset.
- Watchdog:
  - 8-bit counter clears on every state change.
  - Increments each cycle spent in FETCH/MEMREAD/MEMWRITE with mem_ready=0.
  - If MEM_TIMEOUT≠0 and counter reaches MEM_TIMEOUT-1 with mem_ready still 0: next state HALT, bus_error set, counter saturates.
  - mem_ready=1 in the same cycle as the limit wins: normal transition, no error.
- Instruction latency with zero-wait memory:
  - lw 5 cycles
  - sw 4 cycles
  - R-type 4 cycles
  - beq 3 cycles
  - each wait cycle adds 1.
- Reset mid-instruction: abandons the operation immediately; no strobe is emitted after rst rises.

Test Plan:
- lw (opcode 0000011), mem_ready=1 always → state_dbg 0,1,2,3,4,0; reg_write=1 and result_src=01 only in cycle 5; retire pulses once.
- R-type (0110011) → states 0,1,6,7,0; alu_op=10 in EXECR; reg_write=1 with result_src=00 in ALUWB.
- beq with zero=1 then zero=0 → BEQ shows alu_op=01; pc_write=1 in the first case and 0 in the second; both return to FETCH after 3 cycles.
- sw with mem_ready low 3 cycles in MEMWRITE, MEM_TIMEOUT=16 → mem_write held 4 cycles; retire only on the ready cycle; no bus_error.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH → HALT entered after 4 cycles; bus_error=1; all strobes 0 thereafter; recovers only via rst.
- opcode 0010011 → HALT from DECODE with illegal_instr=1. Separately, rst asserted during MEMREAD → state_dbg=0 asynchronously and strobes 0 while rst high.
